// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer.
// Op-select codes and FSM state encoding.
package alu_pkg;

    localparam logic [1:0] OP_OR_NB = 2'b00;
    localparam logic [1:0] OP_NOT_A = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;
    localparam logic [1:0] OP_ADD   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_serial_seq_if.sv
// Request/result bundle of the bit-serial ALU sequencer.
// master drives the request, slave returns the result.
interface alu_serial_seq_if #(
    parameter int WIDTH = 8
);
    logic             Start;
    logic [1:0]       S;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CarryIn;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] F;
    logic             CarryOut;

    modport master (
        output Start, S, A, B, CarryIn,
        input  Busy, Done, F, CarryOut
    );

    modport slave (
        input  Start, S, A, B, CarryIn,
        output Busy, Done, F, CarryOut
    );
endinterface

// File: rtl/alu_slice.sv
// Combinational 1-bit ALU slice.
// Four ops; carry is meaningful only for increment and add.
module alu_slice
    import alu_pkg::*;
(
    input  logic [1:0] S,
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    output logic       f,
    output logic       cout
);

    // Per-bit result and carry for the selected op
    always_comb begin
        f    = 1'b0;
        cout = 1'b0;
        unique case (S)
            OP_OR_NB: f = a | ~b;
            OP_NOT_A: f = ~a;
            OP_INC: begin
                f    = a ^ cin;
                cout = a & cin;
            end
            OP_ADD: begin
                f    = a ^ b ^ cin;
                cout = (a & b) | (a & cin) | (b & cin);
            end
            default: begin
                f    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial WIDTH-bit ALU: one slice, LSB first, one bit per clock.
// Result word and final carry are published on the Done cycle.
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic Clock,
    input  logic Reset_n,
    alu_serial_seq_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_f_sh;
    logic [1:0]       r_op;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_f;
    logic             r_cout;

    logic             w_accept;
    logic             w_last;
    logic             w_c_init;
    logic             w_f;
    logic             w_cout;
    logic [WIDTH-1:0] w_f_nxt;

    assign w_accept = bus.Start && (r_state != ST_RUN);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_f_nxt  = {w_f, r_f_sh};

    assign w_c_init = (bus.S == OP_INC) ? 1'b1 :
                      (bus.S == OP_ADD) ? bus.CarryIn : 1'b0;

    alu_slice u_slice (
        .S    (r_op),
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_c),
        .f    (w_f),
        .cout (w_cout)
    );

    // FSM state register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Next state: accept from IDLE/DONE, leave RUN on the last bit
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (bus.Start) w_next = ST_RUN;
            ST_RUN:  if (w_last)    w_next = ST_DONE;
            ST_DONE: w_next = bus.Start ? ST_RUN : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand latch, serial shift, carry/counter and result publish
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_f_sh <= '0;
            r_op   <= OP_OR_NB;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_f    <= '0;
            r_cout <= 1'b0;
        end else if (w_accept) begin
            r_a_sh <= bus.A;
            r_b_sh <= bus.B;
            r_op   <= bus.S;
            r_c    <= w_c_init;
            r_cnt  <= '0;
        end else if (r_state == ST_RUN) begin
            r_a_sh <= r_a_sh >> 1;
            r_b_sh <= r_b_sh >> 1;
            r_f_sh <= w_f_nxt[WIDTH-1:1];
            r_c    <= w_cout;
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) begin
                r_f    <= w_f_nxt;
                r_cout <= w_cout;
            end
        end
    end

    assign bus.Busy     = (r_state == ST_RUN);
    assign bus.Done     = (r_state == ST_DONE);
    assign bus.F        = r_f;
    assign bus.CarryOut = r_cout;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq (WIDTH=8 and WIDTH=4 instances).
// Vector table, corner sequences, random ops and an exhaustive 4-bit add sweep.
module tb_alu_serial_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tot = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    alu_serial_seq_if #(.WIDTH(8)) bus8 ();
    alu_serial_seq_if #(.WIDTH(4)) bus4 ();

    alu_serial_seq #(.WIDTH(8)) u_dut8 (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus8.slave)
    );

    alu_serial_seq #(.WIDTH(4)) u_dut4 (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus4.slave)
    );

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] f;
        logic       co;
    } vec_t;

    // Reference: word-level arithmetic, {carry, result}
    function automatic logic [8:0] ref8(input logic [1:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic ci);
        case (op)
            2'b00:   ref8 = {1'b0, a | ~b};
            2'b01:   ref8 = {1'b0, ~a};
            2'b10:   ref8 = {1'b0, a} + 9'd1;
            default: ref8 = {1'b0, a} + {1'b0, b} + {8'd0, ci};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic op8(input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic ci,
                       output logic [7:0] f, output logic co,
                       output int lat);
        @(negedge clk);
        bus8.Start = 1'b1;
        bus8.S = op;
        bus8.A = a;
        bus8.B = b;
        bus8.CarryIn = ci;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        bus8.Start = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (bus8.Done) begin
                lat = n;
                break;
            end
        end
        f = bus8.F;
        co = bus8.CarryOut;
    endtask

    initial begin
        vec_t       tv[6];
        logic [7:0] f;
        logic       co;
        int         lat;
        int         ndone;
        int         dcyc;
        logic [7:0] fdone;
        logic [8:0] e;
        logic [8:0] expq[$];
        logic [1:0] rop;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rci;
        logic [4:0] e4;

        tv[0] = '{2'b11, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        tv[1] = '{2'b11, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1};
        tv[2] = '{2'b10, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1};
        tv[3] = '{2'b10, 8'h3E, 8'h00, 1'b0, 8'h3F, 1'b0};
        tv[4] = '{2'b01, 8'h5A, 8'h00, 1'b0, 8'hA5, 1'b0};
        tv[5] = '{2'b00, 8'h0F, 8'hF0, 1'b0, 8'h0F, 1'b0};

        bus8.Start = 1'b0;
        bus8.S = 2'b00;
        bus8.A = '0;
        bus8.B = '0;
        bus8.CarryIn = 1'b0;
        bus4.Start = 1'b0;
        bus4.S = 2'b00;
        bus4.A = '0;
        bus4.B = '0;
        bus4.CarryIn = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, bus8.Busy}, 0);
        chk("rst_done", {31'd0, bus8.Done}, 0);
        chk("rst_f", {24'd0, bus8.F}, 0);
        chk("rst_cout", {31'd0, bus8.CarryOut}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            op8(tv[i].op, tv[i].a, tv[i].b, tv[i].ci, f, co, lat);
            chk($sformatf("vec%0d_lat", i), lat, 8);
            chk($sformatf("vec%0d_f", i), {24'd0, f}, {24'd0, tv[i].f});
            chk($sformatf("vec%0d_co", i), {31'd0, co}, {31'd0, tv[i].co});
        end

        // Start pulsed mid-RUN with a different A must be ignored
        @(negedge clk);
        bus8.Start = 1'b1;
        bus8.S = 2'b11;
        bus8.A = 8'h21;
        bus8.B = 8'h13;
        bus8.CarryIn = 1'b0;
        @(posedge clk);
        ndone = 0;
        dcyc = 0;
        fdone = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            bus8.Start = (c == 3);
            if (c == 3) bus8.A = 8'hC0;
            @(posedge clk);
            #1;
            if (bus8.Done) begin
                ndone++;
                dcyc = c;
                fdone = bus8.F;
            end
        end
        chk("midstart_ndone", ndone, 1);
        chk("midstart_cyc", dcyc, 8);
        chk("midstart_f", {24'd0, fdone}, 32'h34);

        // Asynchronous reset while bit 3 of an add is in flight
        @(negedge clk);
        bus8.Start = 1'b1;
        bus8.S = 2'b11;
        bus8.A = 8'h12;
        bus8.B = 8'h34;
        @(posedge clk);
        @(negedge clk);
        bus8.Start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, bus8.Busy}, 0);
        chk("arst_done", {31'd0, bus8.Done}, 0);
        chk("arst_f", {24'd0, bus8.F}, 0);
        chk("arst_cout", {31'd0, bus8.CarryOut}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        op8(2'b11, 8'hA5, 8'h6C, 1'b1, f, co, lat);
        e = ref8(2'b11, 8'hA5, 8'h6C, 1'b1);
        chk("post_rst_lat", lat, 8);
        chk("post_rst_f", {24'd0, f}, {24'd0, e[7:0]});
        chk("post_rst_co", {31'd0, co}, {31'd0, e[8]});

        // Random ops against the word-level model
        for (int i = 0; i < 60; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = 8'($urandom);
            rb = 8'($urandom);
            rci = 1'($urandom);
            op8(rop, ra, rb, rci, f, co, lat);
            e = ref8(rop, ra, rb, rci);
            chk($sformatf("rnd%0d_f", i), {23'd0, co, f}, {23'd0, e});
            chk($sformatf("rnd%0d_lat", i), lat, 8);
        end

        // Start held high: one op every 9 cycles, new A each Done
        @(negedge clk);
        bus8.S = 2'b11;
        bus8.B = 8'h5C;
        bus8.CarryIn = 1'b1;
        bus8.A = 8'($urandom);
        bus8.Start = 1'b1;
        expq.push_back(ref8(2'b11, bus8.A, 8'h5C, 1'b1));
        @(posedge clk);
        ndone = 0;
        for (int c = 1; c <= 44; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b2b_done%0d", c), {31'd0, bus8.Done},
                {31'd0, (c % 9) == 8});
            chk($sformatf("b2b_busy%0d", c), {31'd0, bus8.Busy},
                {31'd0, (c % 9) != 8});
            if ((c % 9) == 8) begin
                ndone++;
                e = (expq.size() > 0) ? expq.pop_front() : 9'h1FF;
                chk($sformatf("b2b_f%0d", c),
                    {23'd0, bus8.CarryOut, bus8.F}, {23'd0, e});
                if (c < 44) begin
                    bus8.A = 8'($urandom);
                    expq.push_back(ref8(2'b11, bus8.A, 8'h5C, 1'b1));
                end
            end
        end
        @(negedge clk);
        bus8.Start = 1'b0;
        chk("b2b_ndone", ndone, 5);
        chk("b2b_qempty", expq.size(), 0);

        // Exhaustive 4-bit add sweep on the WIDTH=4 instance
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    @(negedge clk);
                    bus4.Start = 1'b1;
                    bus4.S = 2'b11;
                    bus4.A = 4'(a);
                    bus4.B = 4'(b);
                    bus4.CarryIn = 1'(ci);
                    @(posedge clk);
                    @(negedge clk);
                    bus4.Start = 1'b0;
                    lat = 0;
                    for (int n = 1; n <= 10; n++) begin
                        @(posedge clk);
                        #1;
                        if (bus4.Done) begin
                            lat = n;
                            break;
                        end
                    end
                    e4 = 5'(a + b + ci);
                    chk($sformatf("sweep_%0h_%0h_%0d", a, b, ci),
                        {23'd0, lat[3:0], bus4.CarryOut, bus4.F},
                        {23'd0, 4'd4, e4});
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
